// File: rtl/collatz_range_scan_if.sv
// rtl/collatz_range_scan_if.sv - front-panel bus between controller and Collatz range engine
interface collatz_range_scan_if;
    logic        go;
    logic [31:0] start;
    logic        done;
    logic [15:0] count;

    modport master (output go, output start, input done, input count);
    modport slave  (input go, input start, output done, output count);
endinterface

// File: rtl/collatz_range_scan.sv
// rtl/collatz_range_scan.sv - Collatz sequence lengths for a block of consecutive start values
module collatz_range_scan #(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    collatz_range_scan_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LOAD, ITER, WRITE, DONE} state_t;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

    state_t                   state_q, state_d;
    logic [31:0]              base_q, base_d;
    logic [31:0]              n_q, n_d;
    logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
    logic [15:0]              len_q, len_d;
    logic [15:0]              count_q;
    logic [15:0]              len_inc;
    logic [33:0]              n_x3p1;
    logic                     ram_we;

    logic [15:0] ram_q [2**RAM_ADDR_BITS];

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        n_d     = n_q;
        idx_d   = idx_q;
        len_d   = len_q;
        ram_we  = 1'b0;
        len_inc = (len_q == 16'hFFFF) ? 16'hFFFF : len_q + 16'd1;
        n_x3p1  = {2'b00, n_q} + {1'b0, n_q, 1'b0} + 34'd1;

        case (state_q)
            IDLE, DONE: begin
                if (bus.go) begin
                    base_d  = bus.start;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                n_d   = base_q + 32'(idx_q);
                len_d = 16'd1;
                if (n_d == 32'd0) begin
                    len_d   = 16'd0;
                    state_d = WRITE;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                if (n_q == 32'd1) begin
                    state_d = WRITE;
                end else if (!n_q[0]) begin
                    n_d   = n_q >> 1;
                    len_d = len_inc;
                    if (len_inc == 16'hFFFF) state_d = WRITE;
                end else if (n_x3p1[33:32] != 2'b00) begin
                    // 3n+1 no longer fits the 32-bit datapath: report as saturated
                    len_d   = 16'hFFFF;
                    state_d = WRITE;
                end else begin
                    n_d   = n_x3p1[31:0];
                    len_d = len_inc;
                    if (len_inc == 16'hFFFF) state_d = WRITE;
                end
            end
            WRITE: begin
                ram_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            // read port is live only once results are complete
            if (state_q == DONE) count_q <= ram_q[bus.start[RAM_ADDR_BITS-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[idx_q] <= len_q;
    end

    assign bus.done  = (state_q == DONE);
    assign bus.count = count_q;

endmodule

// File: tb/tb_collatz_range_scan.sv
// tb/tb_collatz_range_scan.sv - self-checking bench for collatz_range_scan
module tb_collatz_range_scan;
    localparam int WORDS = 32;
    localparam int ABITS = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rises = 0;
    logic done_prev = 1'b0;

    collatz_range_scan_if dut_if ();
    collatz_range_scan_if small_if ();

    collatz_range_scan #(.RAM_WORDS(WORDS), .RAM_ADDR_BITS(ABITS)) dut (
        .clk(clk), .reset(reset), .bus(dut_if)
    );
    collatz_range_scan #(.RAM_WORDS(2), .RAM_ADDR_BITS(1)) small_dut (
        .clk(clk), .reset(reset), .bus(small_if)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (dut_if.done && !done_prev) rises <= rises + 1;
        done_prev <= dut_if.done;
    end

    function automatic logic [15:0] ref_len(input logic [31:0] v);
        longint unsigned n;
        int unsigned     len;
        if (v == 32'd0) return 16'd0;
        n   = 64'(v);
        len = 1;
        while (n != 1) begin
            if (n % 2 == 0) n = n / 2;
            else begin
                n = 3 * n + 1;
                if (n > 64'hFFFF_FFFF) return 16'hFFFF;
            end
            len++;
            if (len >= 65535) return 16'hFFFF;
        end
        return 16'(len);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_go(input logic [31:0] base);
        @(negedge clk);
        dut_if.start = base;
        dut_if.go    = 1'b1;
        @(negedge clk);
        dut_if.go    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!dut_if.done && cyc < 40000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " done"}, 32'(dut_if.done), 32'd1);
    endtask

    task automatic read_addr(input logic [31:0] a, output logic [15:0] c);
        @(negedge clk);
        dut_if.start = a;
        @(posedge clk);
        #1 c = dut_if.count;
    endtask

    task automatic verify(input string tag, input logic [31:0] base);
        logic [15:0] c;
        for (int i = 0; i < WORDS; i++) begin
            read_addr(32'(i), c);
            check($sformatf("%s[%0d]", tag, i), 32'(c), 32'(ref_len(base + 32'(i))));
        end
    endtask

    task automatic run(input string tag, input logic [31:0] base);
        int r0 = rises;
        pulse_go(base);
        wait_done(tag);
        @(negedge clk);
        check({tag, " done rises"}, 32'(rises - r0), 32'd1);
    endtask

    initial begin
        logic [15:0] c;
        logic [31:0] rb;
        int          r0;
        int          cyc;

        dut_if.go = 1'b0;   dut_if.start = '0;
        small_if.go = 1'b0; small_if.start = '0;
        #25;
        check("reset done", 32'(dut_if.done), 32'd0);
        check("reset count", 32'(dut_if.count), 32'd0);
        check("reset small done", 32'(small_if.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run("s1", 32'd1);
        read_addr(32'd0, c);  check("s1 a0", 32'(c), 32'd1);
        read_addr(32'd1, c);  check("s1 a1", 32'(c), 32'd2);
        @(negedge clk);
        dut_if.start = 32'd2;
        #1 check("s1 latency hold", 32'(dut_if.count), 32'd2);
        @(posedge clk);
        #1 check("s1 a2", 32'(dut_if.count), 32'd8);
        read_addr(32'd26, c); check("s1 a26", 32'(c), 32'h70);
        verify("s1", 32'd1);

        run("s0", 32'd0);
        read_addr(32'd0, c); check("s0 a0", 32'(c), 32'd0);
        read_addr(32'd1, c); check("s0 a1", 32'(c), 32'd1);
        read_addr(32'd3, c); check("s0 a3", 32'(c), 32'd8);

        @(negedge clk);
        small_if.start = 32'hFFFF_FFFF;
        small_if.go    = 1'b1;
        @(negedge clk);
        small_if.go    = 1'b0;
        cyc = 0;
        while (!small_if.done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("ovf done", 32'(small_if.done), 32'd1);
        small_if.start = 32'd0;
        @(posedge clk);
        #1 check("ovf a0", 32'(small_if.count), 32'hFFFF);
        @(negedge clk);
        small_if.start = 32'd1;
        @(posedge clk);
        #1 check("ovf a1", 32'(small_if.count), 32'd0);

        r0 = rises;
        pulse_go(32'd1);
        repeat (20) @(negedge clk);
        dut_if.start = 32'd100;
        dut_if.go    = 1'b1;
        @(negedge clk);
        dut_if.go    = 1'b0;
        wait_done("midgo");
        @(negedge clk);
        check("midgo rises", 32'(rises - r0), 32'd1);
        verify("midgo", 32'd1);

        pulse_go(32'd3);
        repeat (30) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("abort done", 32'(dut_if.done), 32'd0);
        check("abort count", 32'(dut_if.count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run("s5", 32'd5);
        read_addr(32'd0, c); check("s5 a0", 32'(c), 32'd6);
        verify("s5", 32'd5);

        r0 = rises;
        pulse_go(32'd7);
        check("s7 done drop", 32'(dut_if.done), 32'd0);
        wait_done("s7");
        @(negedge clk);
        check("s7 rises", 32'(rises - r0), 32'd1);
        read_addr(32'd0, c); check("s7 a0", 32'(c), 32'd17);
        verify("s7", 32'd7);

        for (int k = 0; k < 4; k++) begin
            rb = (k < 2) ? $urandom() : 32'($urandom_range(1, 1000000));
            run($sformatf("rnd%0d", k), rb);
            verify($sformatf("rnd%0d", k), rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
